// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings and the
// requester selection rule.
package uart_pkg;

    typedef enum logic [3:0] {
        ARB_IDLE        = 4'b0001,
        ARB_WAIT_BSY_HI = 4'b0010,
        ARB_WAIT_BSY_LO = 4'b0100,
        ARB_RELEASE     = 4'b1000
    } arb_state_e;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_e;

    // Open packet pins the grant to its owner; otherwise contention goes to the non-owner.
    function automatic logic rr_pick(input logic v0, input logic v1,
                                     input logic owner, input logic locked);
        logic pick;
        if (locked) begin
            pick = owner;
        end else if (v0 && v1) begin
            pick = ~owner;
        end else if (v1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/UartTx.sv
// 8N1 serializer: latches data on go while idle, sends start, 8 bits LSB first,
// stop. bsy drops one cycle before the stop bit ends so a follower can chain tightly.
module UartTx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 66_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       go,
    output logic       tx,
    output logic       bsy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_EARLY = CW'(CLKS_PER_BIT - 2);

    ser_state_e     state_r, state_s;
    logic [CW-1:0]  cnt_r;
    logic [2:0]     bit_r;
    logic [7:0]     shift_r;
    logic           tx_r;
    logic           bsy_r;
    logic           bit_end_s;

    assign bit_end_s = (cnt_r == CNT_LAST);
    assign tx        = tx_r;
    assign bsy       = bsy_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SER_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            SER_IDLE:  if (go) state_s = SER_START; else state_s = SER_IDLE;
            SER_START: if (bit_end_s) state_s = SER_DATA; else state_s = SER_START;
            SER_DATA:  if (bit_end_s && (bit_r == 3'd7)) state_s = SER_STOP; else state_s = SER_DATA;
            SER_STOP:  if (bit_end_s) state_s = SER_IDLE; else state_s = SER_STOP;
            default:   state_s = SER_IDLE;
        endcase
    end

    // Bit timing, shift register and registered line/busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
            bsy_r   <= 1'b0;
        end else begin
            case (state_r)
                SER_IDLE: begin
                    cnt_r <= '0;
                    bit_r <= 3'd0;
                    if (go) begin
                        shift_r <= data;
                        tx_r    <= 1'b0;
                        bsy_r   <= 1'b1;
                    end
                end
                SER_START: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        tx_r  <= shift_r[0];
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                SER_DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (bit_r == 3'd7) begin
                            tx_r <= 1'b1;
                        end else begin
                            bit_r   <= bit_r + 3'd1;
                            shift_r <= {1'b0, shift_r[7:1]};
                            tx_r    <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                SER_STOP: begin
                    if (cnt_r == CNT_EARLY) bsy_r <= 1'b0;
                    if (bit_end_s) cnt_r <= '0;
                    else           cnt_r <= cnt_r + 1'b1;
                end
                default: begin
                    cnt_r <= '0;
                    tx_r  <= 1'b1;
                    bsy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter with packet locking in front of a single
// UART serializer; the granted byte and go are held until the serializer finishes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 66_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       owner,
    output logic       locked
);

    arb_state_e  state_r, state_s;
    logic        go_r, busy_r, owner_r, locked_r;
    logic [7:0]  data_r;
    logic        bsy_s;
    logic        sel_s, sel_valid_s, sel_last_s;
    logic [7:0]  sel_data_s;
    logic        load_s, clr_go_s, release_s;

    assign busy   = busy_r;
    assign owner  = owner_r;
    assign locked = locked_r;
    assign sel_s  = rr_pick(req0_valid, req1_valid, owner_r, locked_r);

    // Route the selected requester's offer
    always_comb begin
        if (sel_s) begin
            sel_valid_s = req1_valid;
            sel_data_s  = req1_data;
            sel_last_s  = req1_last;
        end else begin
            sel_valid_s = req0_valid;
            sel_data_s  = req0_data;
            sel_last_s  = req0_last;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARB_IDLE:        if (load_s) state_s = ARB_WAIT_BSY_HI; else state_s = ARB_IDLE;
            ARB_WAIT_BSY_HI: if (bsy_s) state_s = ARB_WAIT_BSY_LO; else state_s = ARB_WAIT_BSY_HI;
            ARB_WAIT_BSY_LO: if (!bsy_s) state_s = ARB_RELEASE; else state_s = ARB_WAIT_BSY_LO;
            ARB_RELEASE:     state_s = ARB_IDLE;
            default:         state_s = ARB_IDLE;
        endcase
    end

    // Handshake and control strobes decoded from state
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        load_s     = 1'b0;
        clr_go_s   = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (sel_valid_s) begin
                    load_s     = 1'b1;
                    req0_ready = ~sel_s;
                    req1_ready = sel_s;
                end else begin
                    load_s = 1'b0;
                end
            end
            ARB_WAIT_BSY_HI: load_s = 1'b0;
            ARB_WAIT_BSY_LO: if (!bsy_s) clr_go_s = 1'b1; else clr_go_s = 1'b0;
            ARB_RELEASE:     release_s = 1'b1;
            default:         load_s = 1'b0;
        endcase
    end

    // Held byte, go and status registers; owner resets to 1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r   <= 8'h00;
            go_r     <= 1'b0;
            busy_r   <= 1'b0;
            owner_r  <= 1'b1;
            locked_r <= 1'b0;
        end else begin
            if (load_s) begin
                data_r   <= sel_data_s;
                go_r     <= 1'b1;
                busy_r   <= 1'b1;
                owner_r  <= sel_s;
                locked_r <= ~sel_last_s;
            end
            if (clr_go_s)  go_r   <= 1'b0;
            if (release_s) busy_r <= 1'b0;
        end
    end

    UartTx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .data (data_r),
        .go   (go_r),
        .tx   (tx),
        .bsy  (bsy_s)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a UART receiver model decodes tx and
// decoded bytes are compared against bytes queued when the stimulus is offered.
module tb_uart_tx_arbiter;

    localparam int CPB = 10;

    typedef struct packed { logic [7:0] data; logic last; } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       tx, busy, owner, locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t      q0[$], q1[$];
    logic [7:0] exp_q[$], rx_q[$];
    int         rx_t[$];
    logic       rx_stop[$];
    int         acc_port[$];
    logic       obs_owner[$], obs_locked[$];
    int         lock_viol, rdy0_hi;

    uart_tx_arbiter #(.CLK_FREQ(20), .BAUD_RATE(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx(tx), .busy(busy), .owner(owner), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: mid-bit sampling of the serial line
    always begin : rx_mon
        logic [7:0] b;
        int t0;
        @(negedge tx);
        #1 t0 = cyc;
        repeat (CPB / 2) @(posedge clk);
        #1;
        if (tx == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 b[i] = tx;
            end
            repeat (CPB) @(posedge clk);
            #1;
            rx_q.push_back(b);
            rx_t.push_back(t0);
            rx_stop.push_back(tx);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic flush_rx();
        rx_q.delete(); rx_t.delete(); rx_stop.delete(); exp_q.delete();
    endtask

    // Offer queued beats on both ports; logs each acceptance with owner/locked seen after it
    task automatic drive_seq(input int max_acc, input int budget, output int n_acc);
        logic t0, t1;
        n_acc = 0;
        lock_viol = 0; rdy0_hi = 0;
        acc_port.delete(); obs_owner.delete(); obs_locked.delete();
        for (int c = 0; c < budget && n_acc < max_acc; c++) begin
            req0_valid = (q0.size() > 0);
            if (q0.size() > 0) begin req0_data = q0[0].data; req0_last = q0[0].last; end
            req1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin req1_data = q1[0].data; req1_last = q1[0].last; end
            @(negedge clk);
            t0 = req0_valid && req0_ready;
            t1 = req1_valid && req1_ready;
            if (locked && req0_ready) lock_viol++;
            if (req0_ready) rdy0_hi++;
            @(posedge clk);
            #1;
            if (t0) begin
                void'(q0.pop_front()); n_acc++; acc_port.push_back(0);
                obs_owner.push_back(owner); obs_locked.push_back(locked);
            end
            if (t1) begin
                void'(q1.pop_front()); n_acc++; acc_port.push_back(1);
                obs_owner.push_back(owner); obs_locked.push_back(locked);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (rx_q.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00; req0_last = 1'b0; req1_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner: got %b expected 1", owner); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_byte();
        int n, k;
        int lk;
        bit ok;
        flush_rx();
        exp_q.push_back(8'hA5);
        q0.push_back('{8'hA5, 1'b1});
        drive_seq(1, 50, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL single_accept: got %0d expected 1", n); end
        checks++; if (rdy0_hi !== 1) begin errors++; $display("FAIL single_ready_pulse: got %0d cycles expected 1", rdy0_hi); end
        lk = 0;
        for (k = 0; k < 110; k++) begin
            if (locked !== 1'b0) lk++;
            if (busy === 1'b0) break;
            @(posedge clk); #1;
        end
        checks++; if (k > 103) begin errors++; $display("FAIL single_busy_drop: got %0d cycles expected <=103", k); end
        checks++; if (lk !== 0) begin errors++; $display("FAIL single_locked: got %0d locked cycles expected 0", lk); end
        wait_rx(1, 200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_rx_timeout: got %0d bytes expected 1", rx_q.size()); end
        if (ok) begin
            logic [7:0] g;
            logic st;
            g = rx_q.pop_front(); st = rx_stop.pop_front();
            checks++; if (g !== exp_q[0]) begin errors++; $display("FAIL single_data: got %h expected %h", g, exp_q[0]); end
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL single_stop: got %b expected 1", st); end
        end
    endtask

    task automatic test_packet_lock();
        int n;
        bit ok;
        int exp_port[4]    = '{1, 1, 1, 0};
        logic exp_lock[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        flush_rx();
        q1.push_back('{8'h01, 1'b0}); q1.push_back('{8'h02, 1'b0}); q1.push_back('{8'h03, 1'b1});
        q0.push_back('{8'h55, 1'b1});
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h55);
        drive_seq(4, 700, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL lock_accepts: got %0d expected 4", n); end
        checks++; if (lock_viol !== 0) begin errors++; $display("FAIL lock_req0_ready: got %0d cycles expected 0", lock_viol); end
        for (int i = 0; i < 4 && i < acc_port.size(); i++) begin
            checks++; if (acc_port[i] !== exp_port[i]) begin errors++; $display("FAIL lock_port[%0d]: got %0d expected %0d", i, acc_port[i], exp_port[i]); end
            checks++; if (obs_locked[i] !== exp_lock[i]) begin errors++; $display("FAIL lock_locked[%0d]: got %b expected %b", i, obs_locked[i], exp_lock[i]); end
        end
        wait_rx(4, 300, ok);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e, g;
            e = exp_q.pop_front();
            g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL lock_order[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_contention();
        int n;
        bit ok;
        rst = 1'b1; @(posedge clk); @(posedge clk); #1; rst = 1'b0;
        flush_rx();
        q0.push_back('{8'h11, 1'b1}); q0.push_back('{8'h11, 1'b1});
        q1.push_back('{8'h22, 1'b1}); q1.push_back('{8'h22, 1'b1});
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        drive_seq(4, 700, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL cont_accepts: got %0d expected 4", n); end
        for (int i = 0; i < 4 && i < obs_owner.size(); i++) begin
            checks++; if (obs_owner[i] !== 1'(i % 2)) begin errors++; $display("FAIL cont_owner[%0d]: got %b expected %0d", i, obs_owner[i], i % 2); end
        end
        wait_rx(4, 300, ok);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e, g;
            e = exp_q.pop_front();
            g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL cont_order[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_data_stability();
        int n;
        bit ok;
        logic [7:0] g;
        flush_rx();
        q0.push_back('{8'h3C, 1'b1});
        exp_q.push_back(8'h3C);
        drive_seq(1, 50, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL stab_accept: got %0d expected 1", n); end
        for (int c = 0; c < 110; c++) begin
            req0_data = 8'($urandom);
            req0_last = 1'($urandom);
            @(posedge clk); #1;
        end
        wait_rx(1, 100, ok);
        g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        checks++; if (g !== exp_q[0]) begin errors++; $display("FAIL stab_data: got %h expected %h", g, exp_q[0]); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit ok;
        logic [7:0] g;
        flush_rx();
        q1.push_back('{8'h00, 1'b0});
        drive_seq(1, 50, n);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rmid_pre_locked: got %b expected 1", locked); end
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmid_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rmid_locked: got %b expected 0", locked); end
        rst = 1'b0;
        repeat (110) @(posedge clk);
        #1 flush_rx();
        q0.push_back('{8'h9A, 1'b1});
        exp_q.push_back(8'h9A);
        drive_seq(1, 3, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL rmid_accept: got %0d expected 1", n); end
        wait_rx(1, 200, ok);
        g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        checks++; if (g !== exp_q[0]) begin errors++; $display("FAIL rmid_data: got %h expected %h", g, exp_q[0]); end
        q0.delete();
    endtask

    task automatic test_back_to_back();
        int n, gap;
        bit ok;
        flush_rx();
        q0.push_back('{8'hF0, 1'b1}); q0.push_back('{8'h0F, 1'b1});
        exp_q.push_back(8'hF0); exp_q.push_back(8'h0F);
        drive_seq(2, 400, n);
        wait_rx(2, 300, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_rx_timeout: got %0d bytes expected 2", rx_q.size()); end
        if (ok) begin
            gap = rx_t[1] - rx_t[0] - 10 * CPB;
            checks++; if (gap > 3) begin errors++; $display("FAIL b2b_gap: got %0d cycles expected <=3", gap); end
            for (int i = 0; i < 2; i++) begin
                logic [7:0] e, g;
                e = exp_q.pop_front();
                g = rx_q.pop_front();
                checks++; if (g !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, g, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_packet_lock();
        test_contention();
        test_data_stability();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
